cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Datapath consuming the control signals of the instruction-decoder FSM.
- Holds the 16x11 unified program/data RAM, program counter (PC), instruction register (IR), operand register, ALU and result register.
- Returns the registered 11-bit instruction to the decoder.
- Provides a program-load port that owns the RAM while the core is held idle.

Parameters:
- ADDR_W, 4, RAM address width (PC and op1 width)
- DEPTH, 16, RAM words (2**ADDR_W)
- INSTR_W, 11, RAM word / instruction width
- DATA_W, 4, ALU operand/result width; data words use RAM bits [DATA_W-1:0]

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ram_csn  in  1  RAM chip select, active low
- ram_rwn  in  1  1=read, 0=write
- ram_addr_sel  in  1  0=PC, 1=IR.op1
- ram_data_sel  in  1  write data: 0=zero-extended op2, 1=zero-extended result register
- alu_s  in  3  ALU operation select
- alu_cin  in  1  ALU carry in
- pc_inc  in  1  increment PC
- pc_reset  in  1  synchronous clear of PC
- load_mode  in  1  1=program-load port owns RAM; core RAM accesses ignored
- prog_we  in  1  program-load write strobe
- prog_addr  in  ADDR_W  program-load address
- prog_wdata  in  INSTR_W  program-load data
- instruction  out  INSTR_W  IR contents, to decoder
- pc  out  ADDR_W  current PC
- result  out  DATA_W  result register
- carry  out  1  carry/borrow flag from last executed ALU op

Behaviour:
- Reset (async, reset_n=0): PC=0, IR=0, operand=0, result=0, carry=0.
  - RAM contents are not cleared.
  - All outputs reflect these registers, so they all read 0.
- RAM address: ram_addr_sel ? IR[7:4] : PC. Read is combinational; all captures are at clk edge.
- Read cycle (ram_csn=0, ram_rwn=1, load_mode=0):
  - addr_sel=0: IR <= RAM[PC].
  - addr_sel=1: operand <= RAM[op1][DATA_W-1:0].
  - Latency 1 cycle: instruction is valid in the cycle after FETCH; operand is valid in EXECUTE.
- Write cycle (ram_csn=0, ram_rwn=0, load_mode=0): RAM[addr] <= {7'b0, wdata}.
  - wdata = ram_data_sel ? result : IR[3:0].
  - IR, operand and PC are unchanged.
- ram_csn=1: no RAM access; IR and operand hold.
- PC:
  - pc_reset=1: PC <= 0. pc_reset wins over pc_inc.
  - else pc_inc=1: PC <= PC+1, wrapping 15 -> 0.
  - else hold.
  - pc_inc in the FETCH cycle means IR captures the old PC address and PC advances on the same edge.
- ALU (combinational): A = operand, B = IR[3:0], 5-bit internal sum.
  - 000: F=B (STO constant), cout=0
  - 001: {cout,F} = A+B+cin
  - 010: {cout,F} = A+~B+cin; cin=1 gives A-B, and cout=1 means no borrow
  - 011: A&B
  - 100: A|B
  - 101: A^B
  - 110: ~A
  - 111: F=A
  - Logical ops: cout=0.
- Result register: result <= F and carry <= cout on every edge where ram_csn=1 and load_mode=0, i.e. the EXECUTE/INIT cycles.
- load_mode=1:
  - prog_we=1: RAM[prog_addr] <= prog_wdata.
  - Core-side RAM writes and IR/operand/result captures are suppressed.
  - PC still obeys pc_inc/pc_reset.
- Simultaneous load_mode write and core write: load port wins; core write dropped.
- Arithmetic wraps modulo 2**DATA_W; no saturation.

Decomposition:
- Shared package cpu_pkg:
  - opcode/alu_s constants (OP_STO..OP_NOT)
  - field positions: OPC_HI=10, OPC_LO=8, OP1_HI=7, OP1_LO=4, OP2_HI=3, OP2_LO=0
  - ADDR_W, DATA_W, INSTR_W defaults
- One sub-module: alu4 (combinational: a, b, s, cin -> f, cout).
- RAM array, PC, IR and registers stay in cpu_datapath.

Test Plan:
- Load, STO then ADD:
  - Stimulus: with load_mode=1, write RAM[0]=0x0F5 (STO op1=15, op2=5) and RAM[1]=0x1F3 (ADD op1=15, op2=3). Release load_mode and drive the decoder sequence FETCH/LOAD/EXECUTE/STORE twice.
  - Response: RAM[15]=5 after the first STORE, RAM[15]=8 after the second, carry=0, pc=2.
- SUB with borrow:
  - Stimulus: RAM[14]=2, instruction 0x2E5, cin=1.
  - Response: result=0xD, carry=0, RAM[14]=0x00D.
- ADD overflow:
  - Stimulus: RAM[14]=0xF, instruction 0x1E1.
  - Response: result=0, carry=1.
- PC wrap and priority:
  - Stimulus: pc_inc 16 times from 0; then pc_inc=1 and pc_reset=1 together.
  - Response: pc returns to 0 after the 16 increments; pc=0 after the simultaneous strobe.
- Async reset mid-EXECUTE:
  - Stimulus: pull reset_n low between clock edges.
  - Response: pc, instruction, result and carry go to 0 immediately; RAM contents are preserved.
- Idle and load_mode suppression:
  - Stimulus: ram_csn=1 with varying addresses; separately, load_mode=1 with a core write cycle.
  - Response: IR and operand are unchanged with ram_csn=1; under load_mode=1 RAM is unchanged unless prog_we=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction field positions and ALU opcodes
package cpu_pkg;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int INSTR_W = 11;
    localparam int OPC_HI = 10, OPC_LO = 8;
    localparam int OP1_HI = 7,  OP1_LO = 4;
    localparam int OP2_HI = 3,  OP2_LO = 0;
    typedef enum logic [2:0] {
        OP_STO  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_t;
endpackage

// File: rtl/cpu_datapath_alu4.sv
// alu4: combinational ALU; logical ops leave the sum's top bit clear so cout=0
module alu4
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   s,
    input  logic         cin,
    output logic [W-1:0] f,
    output logic         cout
);
    logic [W:0] sum;
    always_comb begin
        sum = '0;
        case (alu_op_t'(s))
            OP_STO:  sum = {1'b0, b};
            OP_ADD:  sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_NOT:  sum = {1'b0, ~a};
            default: sum = {1'b0, a};
        endcase
        f    = sum[W-1:0];
        cout = sum[W];
    end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: unified RAM, PC, IR, operand, ALU and result register driven by decoder controls
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int DATA_W  = cpu_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ram_csn,
    input  logic               ram_rwn,
    input  logic               ram_addr_sel,
    input  logic               ram_data_sel,
    input  logic [2:0]         alu_s,
    input  logic               alu_cin,
    input  logic               pc_inc,
    input  logic               pc_reset,
    input  logic               load_mode,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  result,
    output logic               carry
);
    logic [INSTR_W-1:0] ram [DEPTH];
    logic [INSTR_W-1:0] ir, rdata, wdata;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  operand, f;
    logic               cout, core_rd, core_wr;

    assign addr        = ram_addr_sel ? ir[OP1_HI:OP1_LO] : pc;
    assign rdata       = ram[addr];
    assign wdata       = {(INSTR_W-DATA_W)'(0), ram_data_sel ? result : ir[OP2_HI:OP2_LO]};
    assign core_rd     = !load_mode && !ram_csn && ram_rwn;
    assign core_wr     = !load_mode && !ram_csn && !ram_rwn;
    assign instruction = ir;

    alu4 #(.W(DATA_W)) u_alu (
        .a(operand), .b(ir[OP2_HI:OP2_LO]), .s(alu_s), .cin(alu_cin), .f(f), .cout(cout)
    );

    // the load port takes priority, so a colliding core write is simply lost
    always_ff @(posedge clk) begin
        if (load_mode && prog_we)
            ram[prog_addr] <= prog_wdata;
        else if (core_wr)
            ram[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= '0;
            ir      <= '0;
            operand <= '0;
            result  <= '0;
            carry   <= 1'b0;
        end else begin
            pc <= pc_reset ? '0 : pc_inc ? pc + ADDR_W'(1) : pc;
            if (core_rd && !ram_addr_sel)
                ir <= rdata;
            if (core_rd && ram_addr_sel)
                operand <= rdata[DATA_W-1:0];
            if (!load_mode && ram_csn) begin
                result <= f;
                carry  <= cout;
            end
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed vector table plus hand sequences for program flow, PC, reset and suppression
module tb_cpu_datapath;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        ram_csn = 1'b1, ram_rwn = 1'b1, ram_addr_sel = 1'b0, ram_data_sel = 1'b0;
    logic [2:0]  alu_s = 3'd0;
    logic        alu_cin = 1'b0, pc_inc = 1'b0, pc_reset = 1'b0;
    logic        load_mode = 1'b1, prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [10:0] prog_wdata = 11'd0;
    logic [10:0] instruction;
    logic [3:0]  pc, result;
    logic        carry;
    int          checks = 0, errors = 0;

    cpu_datapath dut (
        .clk(clk), .reset_n(reset_n), .ram_csn(ram_csn), .ram_rwn(ram_rwn),
        .ram_addr_sel(ram_addr_sel), .ram_data_sel(ram_data_sel), .alu_s(alu_s),
        .alu_cin(alu_cin), .pc_inc(pc_inc), .pc_reset(pc_reset), .load_mode(load_mode),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .instruction(instruction), .pc(pc), .result(result), .carry(carry)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [10:0] instr;
        logic [3:0]  a;
        logic        cin;
        logic [3:0]  f;
        logic        c;
    } vec_t;
    vec_t v [11];

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [10:0] d);
        load_mode = 1'b1; ram_csn = 1'b1; prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic fetch();
        load_mode = 1'b0; ram_csn = 1'b0; ram_rwn = 1'b1; ram_addr_sel = 1'b0; pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
    endtask

    task automatic load_op();
        load_mode = 1'b0; ram_csn = 1'b0; ram_rwn = 1'b1; ram_addr_sel = 1'b1;
        step();
    endtask

    task automatic execute(input logic [2:0] s, input logic cin);
        load_mode = 1'b0; ram_csn = 1'b1; alu_s = s; alu_cin = cin;
        step();
    endtask

    task automatic store();
        load_mode = 1'b0; ram_csn = 1'b0; ram_rwn = 1'b0; ram_addr_sel = 1'b1; ram_data_sel = 1'b1;
        step();
        ram_csn = 1'b1; ram_rwn = 1'b1;
    endtask

    initial begin
        v[0]  = '{11'h0E5, 4'h3, 1'b0, 4'h5, 1'b0};
        v[1]  = '{11'h1E3, 4'h4, 1'b0, 4'h7, 1'b0};
        v[2]  = '{11'h2E5, 4'h2, 1'b1, 4'hD, 1'b0};
        v[3]  = '{11'h1E1, 4'hF, 1'b0, 4'h0, 1'b1};
        v[4]  = '{11'h2E3, 4'h7, 1'b1, 4'h4, 1'b1};
        v[5]  = '{11'h3EC, 4'hA, 1'b0, 4'h8, 1'b0};
        v[6]  = '{11'h4E5, 4'hA, 1'b0, 4'hF, 1'b0};
        v[7]  = '{11'h5EF, 4'hA, 1'b0, 4'h5, 1'b0};
        v[8]  = '{11'h6E0, 4'hA, 1'b0, 4'h5, 1'b0};
        v[9]  = '{11'h7E0, 4'h9, 1'b0, 4'h9, 1'b0};
        v[10] = '{11'h1E7, 4'h8, 1'b1, 4'h0, 1'b1};

        #1;
        chk("reset_pc", 16'(pc), 16'h0);
        chk("reset_ir", 16'(instruction), 16'h0);
        chk("reset_result", 16'(result), 16'h0);
        chk("reset_carry", 16'(carry), 16'h0);
        step();
        reset_n = 1'b1;
        step();

        // STO 15,5 then ADD 15,3
        prog(4'd0, 11'h0F5);
        prog(4'd1, 11'h1F3);
        fetch();
        chk("prog_ir0", 16'(instruction), 16'h0F5);
        load_op();
        execute(3'd0, 1'b0);
        chk("prog_sto_result", 16'(result), 16'h5);
        store();
        chk("prog_ram15_first", 16'(dut.ram[15]), 16'h005);
        fetch();
        chk("prog_ir1", 16'(instruction), 16'h1F3);
        load_op();
        execute(3'd1, 1'b0);
        store();
        chk("prog_ram15_second", 16'(dut.ram[15]), 16'h008);
        chk("prog_carry", 16'(carry), 16'h0);
        chk("prog_pc", 16'(pc), 16'h2);

        foreach (v[i]) begin
            prog(4'd0, v[i].instr);
            prog(4'd14, {7'b0, v[i].a});
            load_mode = 1'b0; ram_csn = 1'b1; pc_reset = 1'b1;
            step();
            pc_reset = 1'b0;
            fetch();
            chk($sformatf("vec%0d_ir", i), 16'(instruction), 16'(v[i].instr));
            load_op();
            execute(v[i].instr[10:8], v[i].cin);
            chk($sformatf("vec%0d_result", i), 16'(result), 16'(v[i].f));
            chk($sformatf("vec%0d_carry", i), 16'(carry), 16'(v[i].c));
            store();
            chk($sformatf("vec%0d_ram14", i), 16'(dut.ram[14]), 16'(v[i].f));
        end

        // async reset between edges during EXECUTE
        load_mode = 1'b0; ram_csn = 1'b1; alu_s = 3'd1; alu_cin = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pc", 16'(pc), 16'h0);
        chk("async_ir", 16'(instruction), 16'h0);
        chk("async_result", 16'(result), 16'h0);
        chk("async_carry", 16'(carry), 16'h0);
        chk("async_ram0_kept", 16'(dut.ram[0]), 16'h1E7);
        chk("async_ram15_kept", 16'(dut.ram[15]), 16'h008);
        step();
        reset_n = 1'b1;

        // PC wrap and reset priority
        pc_inc = 1'b1;
        step();
        chk("pc_inc1", 16'(pc), 16'h1);
        for (int k = 0; k < 15; k++) step();
        chk("pc_wrap", 16'(pc), 16'h0);
        for (int k = 0; k < 3; k++) step();
        chk("pc_three", 16'(pc), 16'h3);
        pc_reset = 1'b1;
        step();
        pc_reset = 1'b0; pc_inc = 1'b0;
        chk("pc_reset_priority", 16'(pc), 16'h0);

        // idle holds IR and operand; load_mode suppresses core activity
        prog(4'd0, 11'h7E0);
        prog(4'd14, 11'h006);
        fetch();
        load_op();
        for (int k = 0; k < 4; k++) begin
            ram_addr_sel = k[0]; ram_rwn = k[1]; ram_data_sel = 1'b0;
            execute(3'd7, 1'b0);
            chk($sformatf("idle%0d_ir", k), 16'(instruction), 16'h7E0);
            chk($sformatf("idle%0d_operand", k), 16'(result), 16'h6);
        end
        chk("idle_ram14", 16'(dut.ram[14]), 16'h006);
        load_mode = 1'b1; prog_we = 1'b0; ram_csn = 1'b0; ram_rwn = 1'b0;
        ram_addr_sel = 1'b1; ram_data_sel = 1'b0;
        step();
        chk("load_core_write_dropped", 16'(dut.ram[14]), 16'h006);
        ram_rwn = 1'b1; ram_addr_sel = 1'b0;
        step();
        chk("load_ir_held", 16'(instruction), 16'h7E0);
        ram_csn = 1'b1; alu_s = 3'd0;
        step();
        chk("load_result_held", 16'(result), 16'h6);
        ram_csn = 1'b0; ram_rwn = 1'b0; ram_addr_sel = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd14; prog_wdata = 11'h123;
        step();
        prog_we = 1'b0; ram_csn = 1'b1; ram_rwn = 1'b1;
        chk("load_port_wins", 16'(dut.ram[14]), 16'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
